change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Pay-out end of the vending datapath. The coin-acceptor FSM takes coins in; this block pays change out.
//  It takes a change request in nickel units and drives the coin-ejector solenoids.
//  Each coin is one timed pulse on dime_out or nickel_out, followed by a mandatory gap.
//  Selection is greedy: dimes first, then nickels. Reports completion, the unpaid remainder and errors.
// PARAMETERS
//  AMT_W       5  width of amount/remaining, in nickel units (5 cents each)
//  PULSE_CYC   4  clk cycles a solenoid output is held high per coin (>=1)
//  GAP_CYC     4  clk cycles both solenoids are held low between coins (>=1)
//  DIME_INIT   8  dime stock after reset/refill (CHANGE_INVENTORY_EN only)
//  NICKEL_INIT 8  nickel stock after reset/refill (CHANGE_INVENTORY_EN only)
// PORTS
//  clk        in   1      system clock; single clock domain
//  rst_n      in   1      reset, asynchronous, active-low
//  start      in   1      request strobe; sampled only in IDLE
//  amount     in   AMT_W  change owed in nickel units; captured on the start cycle
//  abort      in   1      stop after the current coin; level or pulse
//  busy       out  1      high from the cycle after start until done
//  dime_out   out  1      dime ejector solenoid drive
//  nickel_out out  1      nickel ejector solenoid drive
//  done       out  1      one-cycle completion pulse
//  remaining  out  AMT_W  units still owed; valid while busy and on done
//  err        out  1      high with done when payout stopped for lack of stock; else 0
//  refill     in   1      reload stock to INIT values (CHANGE_INVENTORY_EN only)
//  dime_cnt   out  8      current dime stock (CHANGE_INVENTORY_EN only)
//  nickel_cnt out  8      current nickel stock (CHANGE_INVENTORY_EN only)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, remaining 0. Under CHANGE_INVENTORY_EN, counts are set to INIT values.
//   Reset mid-pulse drops the solenoid outputs immediately (asynchronous).
//  States: IDLE -> SEL -> PULSE -> GAP -> SEL ... -> DONE -> IDLE.
//  IDLE:  start=1 and abort=0: latch amount into remaining; next state SEL.
//   start and abort together in IDLE: start is ignored.
//  SEL (1 cycle):
//   - abort seen or remaining==0 -> DONE.
//   - remaining>=2 -> dime.
//   - remaining==1 -> nickel.
//   - The selected output rises on the next clock. On that same clock remaining decrements by 2 (dime) or 1 (nickel).
//  PULSE: the selected output is high for exactly PULSE_CYC cycles, then GAP.
//  GAP: both outputs low for exactly GAP_CYC cycles, then SEL.
//  abort: latched (sticky) while busy. A pulse in progress is never truncated; its GAP still completes.
//  DONE: done=1 for one cycle, busy=0 on that cycle, remaining holds its final value; then IDLE.
//  Latency:
//   - start at cycle N: busy high at N+1, first coin output high at N+2.
//   - Each coin costs PULSE_CYC+GAP_CYC+1 cycles.
//  amount==0: SEL goes straight to DONE; done pulses at N+2; no coin output.
//  dime_out and nickel_out are never high in the same cycle.
//  start while busy is ignored; amount changes after the start cycle have no effect.
//  remaining never wraps: it only decrements by a value <= itself.
// CONFIGURATION
//  Macro CHANGE_INVENTORY_EN defined:
//   - Adds refill, dime_cnt and nickel_cnt.
//   - SEL picks a dime only if remaining>=2 and dime_cnt>0; otherwise a nickel if nickel_cnt>0.
//   - If remaining>0 and no usable coin remains -> DONE with err=1.
//   - Each issued coin decrements its count; counts saturate at 0.
//   - refill takes effect in IDLE only; it is ignored while busy.
//  Macro CHANGE_INVENTORY_EN undefined:
//   - Stock is unlimited and the refill/dime_cnt/nickel_cnt ports are absent.
//   - err is tied to 0.
// STRUCTURE
//  Package change_pkg:
//   - state encodings IDLE/SEL/PULSE/GAP/DONE;
//   - NICKEL_UNITS=1 and DIME_UNITS=2;
//   - coin-select encoding COIN_NONE/COIN_NICKEL/COIN_DIME.
//  Sub-module coin_pulse_timer:
//   - loadable down-counter sized for max(PULSE_CYC, GAP_CYC);
//   - inputs load and len; output expire;
//   - used for both the PULSE and GAP phases.
// TESTING
//  T1 reset values: assert rst_n=0 mid-pulse -> dime_out, nickel_out, busy, done, err and remaining drop to 0 asynchronously.
//  T2 amount=7, defaults:
//   - 3 dime pulses then 1 nickel pulse; each pulse 4 cycles, each gap 4 cycles;
//   - done at coin4 end + 5 cycles; remaining=0; err=0.
//  T3 amount=0 -> no coin pulses; done 2 cycles after start; remaining=0.
//  T4 amount=6, abort pulsed mid-way through the 1st dime:
//   - the 1st dime completes its full 4 cycles;
//   - done follows the gap; remaining=4.
//  T5 start held high through the whole job, amount changing -> exactly one job with the captured amount; no restart until IDLE.
//  T6 CHANGE_INVENTORY_EN with DIME_INIT=1, NICKEL_INIT=2, amount=6:
//   - issues 1 dime then 2 nickels;
//   - done with err=1, remaining=2, dime_cnt=0, nickel_cnt=0.
//   - refill in IDLE -> counts return to 1 and 2.

Source files
------------

// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM state and
// coin-select encodings, coin values in nickel units, small helpers.
package change_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SEL   = 3'd1,
      PULSE = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      COIN_NONE   = 2'd0,
      COIN_NICKEL = 2'd1,
      COIN_DIME   = 2'd2
   } coin_t;

   localparam int NICKEL_UNITS = 1;
   localparam int DIME_UNITS   = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Stock counters never go below zero.
   function automatic logic [7:0] sat_dec8(input logic [7:0] v);
      if (v == 8'd0) begin
         return 8'd0;
      end else begin
         return v - 8'd1;
      end
   endfunction

endpackage

// File: rtl/coin_pulse_timer.sv
// Loadable down-counter that times both the solenoid-high phase and the
// inter-coin gap. 'expire' flags the last cycle of the loaded length.
module coin_pulse_timer #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] len,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_r;

   // Count down from the loaded length, resting at zero when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (load) begin
         cnt_r <= len;
      end else if (cnt_r != {CNT_W{1'b0}}) begin
         cnt_r <= cnt_r - CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/change_dispenser.sv
// Change pay-out controller: greedy dime-then-nickel selection, one timed
// solenoid pulse per coin followed by a mandatory low gap.
// Optional feature macro: CHANGE_INVENTORY_EN adds finite coin stock with
// refill and stock-count outputs; without it stock is unlimited, err is 0.
module change_dispenser
   import change_pkg::*;
#(
   parameter int AMT_W     = 5,
   parameter int PULSE_CYC = 4,
   parameter int GAP_CYC   = 4
`ifdef CHANGE_INVENTORY_EN
   ,
   parameter int DIME_INIT   = 8,
   parameter int NICKEL_INIT = 8
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   input  logic             abort,
   output logic             busy,
   output logic             dime_out,
   output logic             nickel_out,
   output logic             done,
   output logic [AMT_W-1:0] remaining,
   output logic             err
`ifdef CHANGE_INVENTORY_EN
   ,
   input  logic             refill,
   output logic [7:0]       dime_cnt,
   output logic [7:0]       nickel_cnt
`endif
);

   localparam int TMR_W = $clog2(max_int(PULSE_CYC, GAP_CYC) + 1);
   localparam logic [TMR_W-1:0] PULSE_LEN = TMR_W'(PULSE_CYC);
   localparam logic [TMR_W-1:0] GAP_LEN   = TMR_W'(GAP_CYC);
   localparam logic [AMT_W-1:0] DIME_AMT   = AMT_W'(DIME_UNITS);
   localparam logic [AMT_W-1:0] NICKEL_AMT = AMT_W'(NICKEL_UNITS);

   state_t           state_r, state_nx_s;
   coin_t            coin_r, coin_nx_s;
   logic [AMT_W-1:0] rem_r, rem_nx_s;
   logic             abort_r, abort_nx_s;
   logic             err_nx_s;
   logic             busy_r, done_r, dime_r, nickel_r, err_r;
   logic             tmr_load_s;
   logic [TMR_W-1:0] tmr_len_s;
   logic             tmr_expire_s;
   logic             use_dime_s, use_nickel_s;

`ifdef CHANGE_INVENTORY_EN
   logic [7:0] dime_cnt_r, dime_cnt_nx_s;
   logic [7:0] nickel_cnt_r, nickel_cnt_nx_s;

   assign use_dime_s   = (rem_r >= DIME_AMT) && (dime_cnt_r != 8'd0);
   assign use_nickel_s = (nickel_cnt_r != 8'd0);
`else
   // Unlimited stock: a nickel can always cover a non-zero remainder.
   assign use_dime_s   = (rem_r >= DIME_AMT);
   assign use_nickel_s = 1'b1;
`endif

   coin_pulse_timer #(
      .CNT_W (TMR_W)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (tmr_load_s),
      .len    (tmr_len_s),
      .expire (tmr_expire_s)
   );

   // Next-state, coin selection, remainder and stock bookkeeping
   always_comb begin
      state_nx_s = state_r;
      coin_nx_s  = coin_r;
      rem_nx_s   = rem_r;
      abort_nx_s = abort_r;
      err_nx_s   = 1'b0;
      tmr_load_s = 1'b0;
      tmr_len_s  = PULSE_LEN;
`ifdef CHANGE_INVENTORY_EN
      dime_cnt_nx_s   = dime_cnt_r;
      nickel_cnt_nx_s = nickel_cnt_r;
`endif
      case (state_r)
         IDLE: begin
            abort_nx_s = 1'b0;
            coin_nx_s  = COIN_NONE;
            // A simultaneous abort cancels the request outright.
            if (start && !abort) begin
               rem_nx_s   = amount;
               state_nx_s = SEL;
            end else begin
               state_nx_s = IDLE;
            end
`ifdef CHANGE_INVENTORY_EN
            if (refill) begin
               dime_cnt_nx_s   = 8'(DIME_INIT);
               nickel_cnt_nx_s = 8'(NICKEL_INIT);
            end else begin
               dime_cnt_nx_s   = dime_cnt_r;
               nickel_cnt_nx_s = nickel_cnt_r;
            end
`endif
         end
         SEL: begin
            abort_nx_s = abort_r | abort;
            if (abort_r || abort || (rem_r == {AMT_W{1'b0}})) begin
               coin_nx_s  = COIN_NONE;
               state_nx_s = DONE;
            end else if (use_dime_s) begin
               coin_nx_s  = COIN_DIME;
               rem_nx_s   = rem_r - DIME_AMT;
               state_nx_s = PULSE;
               tmr_load_s = 1'b1;
               tmr_len_s  = PULSE_LEN;
`ifdef CHANGE_INVENTORY_EN
               dime_cnt_nx_s = sat_dec8(dime_cnt_r);
`endif
            end else if (use_nickel_s) begin
               coin_nx_s  = COIN_NICKEL;
               rem_nx_s   = rem_r - NICKEL_AMT;
               state_nx_s = PULSE;
               tmr_load_s = 1'b1;
               tmr_len_s  = PULSE_LEN;
`ifdef CHANGE_INVENTORY_EN
               nickel_cnt_nx_s = sat_dec8(nickel_cnt_r);
`endif
            end else begin
               // Owed money but no coin can pay it: stop and flag.
               coin_nx_s  = COIN_NONE;
               state_nx_s = DONE;
               err_nx_s   = 1'b1;
            end
         end
         PULSE: begin
            abort_nx_s = abort_r | abort;
            if (tmr_expire_s) begin
               coin_nx_s  = COIN_NONE;
               state_nx_s = GAP;
               tmr_load_s = 1'b1;
               tmr_len_s  = GAP_LEN;
            end else begin
               state_nx_s = PULSE;
            end
         end
         GAP: begin
            abort_nx_s = abort_r | abort;
            if (tmr_expire_s) begin
               state_nx_s = SEL;
            end else begin
               state_nx_s = GAP;
            end
         end
         DONE: begin
            abort_nx_s = 1'b0;
            state_nx_s = IDLE;
         end
         default: begin
            abort_nx_s = 1'b0;
            coin_nx_s  = COIN_NONE;
            state_nx_s = IDLE;
         end
      endcase
   end

   // FSM state, selected coin, remainder and sticky abort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         coin_r  <= COIN_NONE;
         rem_r   <= {AMT_W{1'b0}};
         abort_r <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         coin_r  <= coin_nx_s;
         rem_r   <= rem_nx_s;
         abort_r <= abort_nx_s;
      end
   end

   // Outputs registered from the next state so they line up with it exactly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         dime_r   <= 1'b0;
         nickel_r <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         busy_r   <= (state_nx_s inside {SEL, PULSE, GAP});
         done_r   <= (state_nx_s == DONE);
         dime_r   <= (state_nx_s == PULSE) && (coin_nx_s == COIN_DIME);
         nickel_r <= (state_nx_s == PULSE) && (coin_nx_s == COIN_NICKEL);
         err_r    <= err_nx_s;
      end
   end

`ifdef CHANGE_INVENTORY_EN
   // Coin stock: INIT on reset, reduced per issued coin, reloaded by refill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dime_cnt_r   <= 8'(DIME_INIT);
         nickel_cnt_r <= 8'(NICKEL_INIT);
      end else begin
         dime_cnt_r   <= dime_cnt_nx_s;
         nickel_cnt_r <= nickel_cnt_nx_s;
      end
   end

   assign dime_cnt   = dime_cnt_r;
   assign nickel_cnt = nickel_cnt_r;
`endif

   assign busy       = busy_r;
   assign done       = done_r;
   assign dime_out   = dime_r;
   assign nickel_out = nickel_r;
   assign remaining  = rem_r;
   assign err        = err_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser. Job vectors carry their expected
// coin mix, done offset, remainder and err; each is queued when the job is
// started and popped when done appears. Coin pulses are checked for offset,
// type, length and exclusivity on the fly.
module tb_change_dispenser;

   localparam int PULSE_CYC = 4;
   localparam int GAP_CYC   = 4;
   localparam int COIN_CYC  = PULSE_CYC + GAP_CYC + 1;
   localparam int BUDGET    = 200;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [4:0] amount = 5'd0;
   logic       busy, dime_out, nickel_out, done, err;
   logic [4:0] remaining;
`ifdef CHANGE_INVENTORY_EN
   logic       refill = 1'b0;
   logic [7:0] dime_cnt, nickel_cnt;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0] amount;
      int         abort_cyc;   // offset from start cycle at which abort pulses, -1 none
      int         n_dime;
      int         n_nickel;
      int         done_off;    // done cycle offset from the start cycle
      logic [4:0] rem;
      logic       err;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[$];

   change_dispenser #(
      .AMT_W     (5),
      .PULSE_CYC (PULSE_CYC),
      .GAP_CYC   (GAP_CYC)
`ifdef CHANGE_INVENTORY_EN
      ,
      .DIME_INIT   (1),
      .NICKEL_INIT (2)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .amount     (amount),
      .abort      (abort),
      .busy       (busy),
      .dime_out   (dime_out),
      .nickel_out (nickel_out),
      .done       (done),
      .remaining  (remaining),
      .err        (err)
`ifdef CHANGE_INVENTORY_EN
      ,
      .refill     (refill),
      .dime_cnt   (dime_cnt),
      .nickel_cnt (nickel_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic run_vec(input vec_t v, input bit hold_start);
      int   coin_idx = 0;
      int   plen = 0;
      bit   prev_any = 1'b0;
      bit   got_done = 1'b0;
      bit   any_s;
      vec_t e;
      @(posedge clk); #1;
      start  = 1'b1;
      amount = v.amount;
      abort  = 1'b0;
      exp_q.push_back(v);
      for (int c = 0; c < BUDGET && !got_done; c++) begin
         @(negedge clk);
         any_s = dime_out | nickel_out;
         chk("exclusive", int'(dime_out & nickel_out), 0);
         if (any_s && !prev_any) begin
            chk("coin_offset", c, 2 + COIN_CYC * coin_idx);
            if (dime_out) begin
               chk("coin_is_dime", int'(coin_idx < v.n_dime), 1);
            end else begin
               chk("coin_is_nickel", int'(coin_idx >= v.n_dime), 1);
            end
            coin_idx++;
            plen = 0;
         end
         if (any_s) plen++;
         if (!any_s && prev_any) chk("pulse_len", plen, PULSE_CYC);
         prev_any = any_s;
         if (c >= 1 && !done) chk("busy_in_job", int'(busy), 1);
         if (done) begin
            got_done = 1'b1;
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("done_offset", c, e.done_off);
               chk("remaining", int'(remaining), int'(e.rem));
               chk("err", int'(err), int'(e.err));
               chk("busy_on_done", int'(busy), 0);
               chk("coin_count", coin_idx, e.n_dime + e.n_nickel);
            end
         end
         @(posedge clk); #1;
         start = hold_start && !got_done;
         if (hold_start) amount = 5'($urandom);
         abort = (c + 1 == v.abort_cyc);
      end
      if (!got_done) begin
         chk("done_timeout", 0, 1);
         exp_q.delete();
      end
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("rem_holds", int'(remaining), int'(v.rem));
      chk("idle_busy", int'(busy), 0);
   endtask

   initial begin
`ifdef CHANGE_INVENTORY_EN
      // DIME_INIT=1, NICKEL_INIT=2: stock runs out mid-payout
      tbl.push_back('{5'd6, -1, 1, 2, 29, 5'd2, 1'b1});
`else
      tbl.push_back('{5'd7,  -1,  3, 1, 38,  5'd0, 1'b0});
      tbl.push_back('{5'd0,  -1,  0, 0, 2,   5'd0, 1'b0});
      tbl.push_back('{5'd6,   4,  1, 0, 11,  5'd4, 1'b0});
      tbl.push_back('{5'd1,  -1,  0, 1, 11,  5'd0, 1'b0});
      tbl.push_back('{5'd2,  -1,  1, 0, 11,  5'd0, 1'b0});
      tbl.push_back('{5'd5,   1,  0, 0, 2,   5'd5, 1'b0});
      tbl.push_back('{5'd4,  10,  1, 0, 11,  5'd2, 1'b0});
      tbl.push_back('{5'd3,   8,  1, 0, 11,  5'd1, 1'b0});
      tbl.push_back('{5'd31, -1, 15, 1, 146, 5'd0, 1'b0});
`endif

      // Power-on reset values
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_dime", int'(dime_out), 0);
      chk("rst_nickel", int'(nickel_out), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_remaining", int'(remaining), 0);
      rst_n = 1'b1;

      // Reset asserted mid-pulse drops everything without a clock edge
      @(posedge clk); #1;
      start  = 1'b1;
      amount = 5'd2;
      @(posedge clk); #1;
      start  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("pre_reset_dime", int'(dime_out), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_dime", int'(dime_out), 0);
      chk("arst_nickel", int'(nickel_out), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_err", int'(err), 0);
      chk("arst_remaining", int'(remaining), 0);
`ifdef CHANGE_INVENTORY_EN
      chk("arst_dime_cnt", int'(dime_cnt), 1);
      chk("arst_nickel_cnt", int'(nickel_cnt), 2);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven jobs
      for (int i = 0; i < tbl.size(); i++) begin
         run_vec(tbl[i], 1'b0);
      end

`ifdef CHANGE_INVENTORY_EN
      chk("empty_dime_cnt", int'(dime_cnt), 0);
      chk("empty_nickel_cnt", int'(nickel_cnt), 0);
      // No stock at all: immediate error stop
      run_vec('{5'd1, -1, 0, 0, 2, 5'd1, 1'b1}, 1'b0);
      @(posedge clk); #1;
      refill = 1'b1;
      @(posedge clk); #1;
      refill = 1'b0;
      @(negedge clk);
      chk("refill_dime_cnt", int'(dime_cnt), 1);
      chk("refill_nickel_cnt", int'(nickel_cnt), 2);
      run_vec('{5'd3, -1, 1, 1, 20, 5'd0, 1'b0}, 1'b0);
      chk("after_dime_cnt", int'(dime_cnt), 0);
      chk("after_nickel_cnt", int'(nickel_cnt), 1);
`else
      // start held for the whole job with amount changing: one job only
      run_vec('{5'd3, -1, 1, 1, 20, 5'd0, 1'b0}, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("no_restart_busy", int'(busy), 0);
      end
      // start together with abort in IDLE is ignored
      @(posedge clk); #1;
      start  = 1'b1;
      abort  = 1'b1;
      amount = 5'd5;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("start_abort_busy", int'(busy), 0);
         chk("start_abort_done", int'(done), 0);
      end
`endif

      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
